hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 4, meaning total EX-occupancy cycles of a multi-cycle op (legal range 2..16).
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_id_rs1_addr / i_id_rs2_addr  in  5 each  source registers of the instruction in ID.
REQ-005 i_id_rs1_used / i_id_rs2_used  in  1 each  the ID instruction actually reads rs1 / rs2.
REQ-006 i_ex_rd_addr  in  5  destination register of the instruction in EX.
REQ-007 i_ex_mem_read  in  1  the instruction in EX is a load.
REQ-008 i_ex_mispred  in  1  EX resolved a branch/jump whose prediction was wrong (single cycle).
REQ-009 i_ex_mdu_start  in  1  a multi-cycle MDU op enters EX this cycle.
REQ-010 i_mem_busy  in  1  data memory not ready (level).
REQ-011 o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall  out  1 each  hold the PC / pipeline register.
REQ-012 o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush  out  1 each  load a NOP bubble into the register.
REQ-013 o_mdu_busy  out  1  FSM is in MDU.
REQ-014 o_stall_cycles  out  32  saturating count of cycles with o_pc_stall=1.

Function
REQ-015 load-use hazard lu = i_ex_mem_read AND i_ex_rd_addr!=0 AND ((rs1_used AND rs1==rd) OR (rs2_used AND rs2==rd)).
REQ-016 FSM states RUN, MDU; 4-bit down-counter cnt.
REQ-017 RUN->MDU when i_ex_mdu_start=1, i_ex_mispred=0, i_mem_busy=0; cnt loaded with MDU_LAT-1.
REQ-018 In MDU: cnt decrements each cycle with i_mem_busy=0; when cnt==1 and i_mem_busy=0, next state RUN; i_ex_mdu_start ignored.
REQ-019 mdu_hold = (RUN AND transition-to-MDU condition) OR (MDU AND cnt!=1); exactly MDU_LAT-1 hold cycles absent mem_busy.
REQ-020 Control outputs are combinational from state, cnt and inputs; zero-latency, strict priority below; unlisted outputs are 0.
REQ-021 P1 i_mem_busy=1: all four stall outputs 1, o_mem_wb_flush 1; FSM and cnt frozen; mispred/lu ignored this cycle.
REQ-022 P2 i_ex_mispred=1: o_if_id_flush=1, o_id_ex_flush=1, no stalls.
REQ-023 P3 mdu_hold: o_pc_stall, o_if_id_stall, o_id_ex_stall=1, o_ex_mem_flush=1.
REQ-024 P4 lu (FSM in RUN, not mdu_hold): o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1 for exactly the detecting cycle.
REQ-025 i_ex_mispred and i_ex_mdu_start together: mispred wins, FSM stays RUN.
REQ-026 o_stall_cycles increments by 1 when o_pc_stall=1; saturates at 32'hFFFF_FFFF (no wrap).

Reset
REQ-027 While i_reset=1 every control output and o_mdu_busy SHALL be 0, regardless of other inputs.
REQ-028 On a clock edge with i_reset=1: state=RUN, cnt=0, o_stall_cycles=0; reset mid-MDU returns to RUN with no residual stall next cycle.

Structure
REQ-029 Shared package hazard_pkg holds the state enum (RUN, MDU) and the MDU_LAT default constant.
REQ-030 One sub-module, lu_detect, holds the combinational load-use comparator of REQ-015; FSM, counter, priority mux stay in hazard_ctrl.

Verification
REQ-031 EX load rd=5, ID rs1=5 rs1_used=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, o_stall_cycles=1; rd=0 same case -> no stall.
REQ-032 MDU_LAT=4, mdu_start at t0 -> hold at t0,t1,t2; none at t3; o_mdu_busy t1..t3; RUN at t4.
REQ-033 mem_busy 2 cycles during MDU cnt=2 -> all stalls + mem_wb_flush both cycles; hold resumes, cnt=1 reached 2 cycles late.
REQ-034 mispred with lu true same cycle -> only if_id_flush=id_ex_flush=1, no stall.
REQ-035 mispred and mdu_start together -> flushes only, o_mdu_busy stays 0.
REQ-036 reset asserted at MDU cnt=3 -> outputs 0 during reset, RUN, o_stall_cycles=0 after; preload counter near 32'hFFFF_FFFF, 3 stall cycles -> holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller: the controller FSM
// state encoding, the default multi-cycle MDU latency and the width of the
// MDU occupancy down-counter.
// ----------------------------------------------------------------------------
package hazard_pkg;

    // Total EX-occupancy cycles of a multi-cycle MDU op (legal range 2..16).
    localparam int MDU_LAT_DEFAULT = 4;

    // Occupancy down-counter width; holds MDU_LAT-1 for the largest MDU_LAT.
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        RUN = 1'b0,   // normal issue
        MDU = 1'b1    // multi-cycle MDU op occupying EX
    } state_e;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_lu_detect.sv
// ----------------------------------------------------------------------------
// lu_detect
// Combinational load-use hazard detector. Flags the case where the
// instruction in EX is a load whose destination register is read by the
// instruction currently in ID. x0 is never a hazard because it is hardwired.
//
// Ports
//   i_id_rs1_addr, i_id_rs2_addr  source registers of the ID instruction
//   i_id_rs1_used, i_id_rs2_used  ID instruction really reads rs1 / rs2
//   i_ex_rd_addr                  destination register of the EX instruction
//   i_ex_mem_read                 EX instruction is a load
//   o_lu                          load-use hazard present this cycle
// ----------------------------------------------------------------------------
module lu_detect (
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic [4:0] i_ex_rd_addr,
    input  logic       i_ex_mem_read,
    output logic       o_lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr);
    assign rs2_hit = i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr);

    assign o_lu = i_ex_mem_read && (i_ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);

endmodule : lu_detect

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller. Produces stall and flush controls for a
// five-stage pipeline from four hazard sources, in strict priority order:
//   1. data memory busy      -> freeze everything, bubble into MEM/WB
//   2. branch mispredict     -> flush IF/ID and ID/EX
//   3. multi-cycle MDU hold  -> hold front end, bubble into EX/MEM
//   4. load-use              -> hold front end one cycle, bubble into ID/EX
// A two-state FSM with a down-counter tracks MDU occupancy of EX. All
// control outputs are combinational (zero latency) and forced low in reset.
//
// Parameters
//   MDU_LAT        total EX-occupancy cycles of an MDU op (2..16)
// Ports
//   i_clk, i_reset             clock; synchronous active-high reset
//   i_id_rs*_addr/_used        ID-stage source operands
//   i_ex_rd_addr, i_ex_mem_read EX-stage destination and load flag
//   i_ex_mispred               EX resolved a mispredicted branch/jump
//   i_ex_mdu_start             MDU op enters EX this cycle
//   i_mem_busy                 data memory not ready
//   o_*_stall                  hold PC / pipeline register
//   o_*_flush                  load a bubble into pipeline register
//   o_mdu_busy                 FSM is in MDU
//   o_stall_cycles             saturating count of cycles with o_pc_stall=1
// ----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs1_addr,
    input  logic [4:0]  i_id_rs2_addr,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic [4:0]  i_ex_rd_addr,
    input  logic        i_ex_mem_read,
    input  logic        i_ex_mispred,
    input  logic        i_ex_mdu_start,
    input  logic        i_mem_busy,
    output logic        o_pc_stall,
    output logic        o_if_id_stall,
    output logic        o_id_ex_stall,
    output logic        o_ex_mem_stall,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_flush,
    output logic        o_mem_wb_flush,
    output logic        o_mdu_busy,
    output logic [31:0] o_stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q;

    logic lu;
    logic mdu_go;
    logic mdu_hold;

    lu_detect u_lu_detect (
        .i_id_rs1_addr (i_id_rs1_addr),
        .i_id_rs2_addr (i_id_rs2_addr),
        .i_id_rs1_used (i_id_rs1_used),
        .i_id_rs2_used (i_id_rs2_used),
        .i_ex_rd_addr  (i_ex_rd_addr),
        .i_ex_mem_read (i_ex_mem_read),
        .o_lu          (lu)
    );

    // An MDU op is accepted only when nothing of higher priority intervenes;
    // a mispredict kills it and a busy memory defers it.
    assign mdu_go   = (state_q == RUN) && i_ex_mdu_start && !i_ex_mispred && !i_mem_busy;

    // The accepting cycle counts as the first hold cycle; the last MDU cycle
    // (cnt==1) releases the front end so the next op issues back-to-back.
    assign mdu_hold = mdu_go || ((state_q == MDU) && (cnt_q != CNT_W'(1)));

    // ------------------------------------------------------------------------
    // FSM next state / counter
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!i_mem_busy) begin
            case (state_q)
                RUN: begin
                    if (mdu_go) begin
                        state_d = MDU;
                        cnt_d   = CNT_LOAD;
                    end
                end
                MDU: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Priority mux for the stall / flush controls
    // ------------------------------------------------------------------------
    always_comb begin
        o_pc_stall     = 1'b0;
        o_if_id_stall  = 1'b0;
        o_id_ex_stall  = 1'b0;
        o_ex_mem_stall = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        o_mem_wb_flush = 1'b0;
        if (i_reset) begin
            // all controls stay low while reset is held
        end else if (i_mem_busy) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_stall = 1'b1;
            o_mem_wb_flush = 1'b1;
        end else if (i_ex_mispred) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
        end else if (mdu_hold) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_flush = 1'b1;
        end else if (lu && (state_q == RUN)) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_flush  = 1'b1;
        end
    end

    assign o_mdu_busy = !i_reset && (state_q == MDU);

    // ------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cycles_q <= '0;
        end else if (o_pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cycles_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl (MDU_LAT=4). Inputs change
// just after the falling edge; outputs are sampled 1 ns later, well before
// the next rising edge. Control outputs are compared as a packed vector:
//   [8] pc_stall   [7] if_id_stall [6] id_ex_stall  [5] ex_mem_stall
//   [4] if_id_fl   [3] id_ex_fl    [2] ex_mem_fl    [1] mem_wb_fl
//   [0] mdu_busy
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [8:0] C_NONE = 9'b0000_0000_0;
    localparam logic [8:0] C_BUSY = 9'b0000_0000_1;
    localparam logic [8:0] C_MEM  = 9'b1111_0001_0;
    localparam logic [8:0] C_MISP = 9'b0000_1100_0;
    localparam logic [8:0] C_HOLD = 9'b1110_0010_0;
    localparam logic [8:0] C_LU   = 9'b1100_0100_0;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [4:0]  i_id_rs1_addr, i_id_rs2_addr;
    logic        i_id_rs1_used, i_id_rs2_used;
    logic [4:0]  i_ex_rd_addr;
    logic        i_ex_mem_read, i_ex_mispred, i_ex_mdu_start, i_mem_busy;
    logic        o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall;
    logic        o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush;
    logic        o_mdu_busy;
    logic [31:0] o_stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    hazard_ctrl #(.MDU_LAT(4)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_id_rs1_addr  (i_id_rs1_addr),
        .i_id_rs2_addr  (i_id_rs2_addr),
        .i_id_rs1_used  (i_id_rs1_used),
        .i_id_rs2_used  (i_id_rs2_used),
        .i_ex_rd_addr   (i_ex_rd_addr),
        .i_ex_mem_read  (i_ex_mem_read),
        .i_ex_mispred   (i_ex_mispred),
        .i_ex_mdu_start (i_ex_mdu_start),
        .i_mem_busy     (i_mem_busy),
        .o_pc_stall     (o_pc_stall),
        .o_if_id_stall  (o_if_id_stall),
        .o_id_ex_stall  (o_id_ex_stall),
        .o_ex_mem_stall (o_ex_mem_stall),
        .o_if_id_flush  (o_if_id_flush),
        .o_id_ex_flush  (o_id_ex_flush),
        .o_ex_mem_flush (o_ex_mem_flush),
        .o_mem_wb_flush (o_mem_wb_flush),
        .o_mdu_busy     (o_mdu_busy),
        .o_stall_cycles (o_stall_cycles)
    );

    logic [8:0] ctl;
    assign ctl = {o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall,
                  o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
                  o_mdu_busy};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_id_rs1_addr  = 5'd0;
        i_id_rs2_addr  = 5'd0;
        i_id_rs1_used  = 1'b0;
        i_id_rs2_used  = 1'b0;
        i_ex_rd_addr   = 5'd0;
        i_ex_mem_read  = 1'b0;
        i_ex_mispred   = 1'b0;
        i_ex_mdu_start = 1'b0;
        i_mem_busy     = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        i_ex_mem_read = 1'b1;
        i_ex_rd_addr  = rd;
        i_id_rs1_addr = rs1;
        i_id_rs1_used = u1;
        i_id_rs2_addr = rs2;
        i_id_rs2_used = u2;
    endtask

    // Advance one clock; return just after the falling edge.
    task automatic cycle();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        @(negedge i_clk);
        // Outputs low in reset even with busy/start asserted.
        i_mem_busy     = 1'b1;
        i_ex_mdu_start = 1'b1;
        #1 check("reset_ctl", 32'(ctl), 32'(C_NONE));
        cycle();
        idle_inputs();
        #1 check("reset_cnt", o_stall_cycles, 32'd0);
        i_reset = 1'b0;
        cycle();
        #1 check("idle_ctl", 32'(ctl), 32'(C_NONE));

        // Load-use via rs1.
        set_lu(5'd5, 5'd5, 1'b1, 5'd9, 1'b0);
        #1 check("lu_rs1", 32'(ctl), 32'(C_LU));
        cycle();
        idle_inputs();
        #1 check("lu_rs1_after", 32'(ctl), 32'(C_NONE));
        check("lu_rs1_cnt", o_stall_cycles, 32'd1);
        // rd = x0: never a hazard.
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 check("lu_x0", 32'(ctl), 32'(C_NONE));
        // rs2 matches but is unused.
        set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        #1 check("lu_rs2_unused", 32'(ctl), 32'(C_NONE));
        // rs2 matches and is used.
        set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        #1 check("lu_rs2", 32'(ctl), 32'(C_LU));
        cycle();
        idle_inputs();
        #1 check("lu_rs2_cnt", o_stall_cycles, 32'd2);

        // MDU occupancy: hold t0..t2, busy t1..t3, RUN at t4. Start kept
        // high through t2 to show it is ignored while in MDU.
        i_ex_mdu_start = 1'b1;
        #1 check("mdu_t0", 32'(ctl), 32'(C_HOLD));
        cycle();
        #1 check("mdu_t1", 32'(ctl), 32'(C_HOLD | C_BUSY));
        cycle();
        #1 check("mdu_t2", 32'(ctl), 32'(C_HOLD | C_BUSY));
        cycle();
        i_ex_mdu_start = 1'b0;
        #1 check("mdu_t3", 32'(ctl), 32'(C_BUSY));
        cycle();
        #1 check("mdu_t4", 32'(ctl), 32'(C_NONE));
        check("mdu_cnt", o_stall_cycles, 32'd5);

        // MDU with memory busy for two cycles at cnt=2; lu ignored in MDU.
        i_ex_mdu_start = 1'b1;
        #1 check("mb_t0", 32'(ctl), 32'(C_HOLD));
        cycle();
        i_ex_mdu_start = 1'b0;
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1 check("mb_t1_lu", 32'(ctl), 32'(C_HOLD | C_BUSY));
        cycle();
        idle_inputs();
        i_mem_busy = 1'b1;
        #1 check("mb_busy1", 32'(ctl), 32'(C_MEM | C_BUSY));
        cycle();
        #1 check("mb_busy2", 32'(ctl), 32'(C_MEM | C_BUSY));
        cycle();
        i_mem_busy = 1'b0;
        #1 check("mb_resume", 32'(ctl), 32'(C_HOLD | C_BUSY));
        cycle();
        #1 check("mb_last", 32'(ctl), 32'(C_BUSY));
        cycle();
        #1 check("mb_run", 32'(ctl), 32'(C_NONE));
        check("mb_cnt", o_stall_cycles, 32'd10);

        // Mispredict beats load-use.
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        i_ex_mispred = 1'b1;
        #1 check("misp_lu", 32'(ctl), 32'(C_MISP));
        cycle();
        idle_inputs();
        #1 check("misp_lu_cnt", o_stall_cycles, 32'd10);

        // Mispredict beats MDU start; FSM stays in RUN.
        i_ex_mispred   = 1'b1;
        i_ex_mdu_start = 1'b1;
        #1 check("misp_mdu", 32'(ctl), 32'(C_MISP));
        cycle();
        idle_inputs();
        #1 check("misp_mdu_after", 32'(ctl), 32'(C_NONE));

        // Reset in the middle of an MDU op (cnt=3).
        i_ex_mdu_start = 1'b1;
        #1 check("rst_mdu_t0", 32'(ctl), 32'(C_HOLD));
        cycle();
        i_ex_mdu_start = 1'b0;
        i_reset = 1'b1;
        #1 check("rst_mdu_in", 32'(ctl), 32'(C_NONE));
        cycle();
        i_reset = 1'b0;
        #1 check("rst_mdu_out", 32'(ctl), 32'(C_NONE));
        check("rst_mdu_cnt", o_stall_cycles, 32'd0);
        cycle();
        #1 check("rst_mdu_next", 32'(ctl), 32'(C_NONE));

        // Saturation: preload near the top, then three stall cycles.
        force dut.stall_cycles_q = 32'hFFFF_FFFD;
        #1 release dut.stall_cycles_q;
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1 check("sat_lu", 32'(ctl), 32'(C_LU));
        cycle();
        #1 check("sat_1", o_stall_cycles, 32'hFFFF_FFFE);
        cycle();
        #1 check("sat_2", o_stall_cycles, 32'hFFFF_FFFF);
        cycle();
        #1 check("sat_3", o_stall_cycles, 32'hFFFF_FFFF);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_hazard_ctrl
